axi_hbm_wr_arb: RTL and testbench

Round-robin write arbiter sharing one HBM pseudo-channel AXI3 write port (256-bit data, 33-bit address, 6-bit ID, 4-bit length) among `N_REQ` requesters. Grants one requester per burst, forwards its AW then its W beats, generates `WLAST`, `WSTRB` and optional data parity, and routes B responses back by ID. Sits between the NTT write-back engines and the HBM PC AXI slave port.

---
 rtl/axi_hbm_wr_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_hbm_wr_arb.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hbm_wr_arb.sv
// Round-robin arbiter sharing one HBM pseudo-channel AXI3 write port among N_REQ requesters.
// Optional feature macro: AXI_HBM_WPARITY_EN enables per-byte W data parity.

package axi_hbm_wr_arb_pkg;

    localparam int ADDR_W = 33;
    localparam int ID_W   = 6;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 256;
    localparam int STRB_W = DATA_W / 8;
    localparam int OUT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W
    } state_t;

    // One parity bit per byte lane: XOR of the eight data bits in that lane.
    function automatic logic [STRB_W-1:0] wparity(input logic [DATA_W-1:0] data);
        logic [STRB_W-1:0] p;
        for (int i = 0; i < STRB_W; i++) begin
            p[i] = ^data[8*i +: 8];
        end
        return p;
    endfunction

endpackage

module axi_hbm_wr_arb
    import axi_hbm_wr_arb_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [N_REQ-1:0]         req_awvalid,
    output logic [N_REQ-1:0]         req_awready,
    input  logic [N_REQ*ADDR_W-1:0]  req_awaddr,
    input  logic [N_REQ*LEN_W-1:0]   req_awlen,
    input  logic [N_REQ-1:0]         req_wvalid,
    output logic [N_REQ-1:0]         req_wready,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_bvalid,
    input  logic [N_REQ-1:0]         req_bready,

    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [ADDR_W-1:0]        m_awaddr,
    output logic [ID_W-1:0]          m_awid,
    output logic [LEN_W-1:0]         m_awlen,

    output logic                     m_wvalid,
    input  logic                     m_wready,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [STRB_W-1:0]        m_wstrb,
    output logic                     m_wlast,
    output logic [STRB_W-1:0]        m_wparity,

    input  logic                     m_bvalid,
    output logic                     m_bready,
    input  logic [ID_W-1:0]          m_bid,

    output logic                     bid_err
);

    localparam int GW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("N_REQ must be in 2..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be in 1..15");
    end

    state_t             state;
    state_t             state_nxt;
    logic [GW-1:0]      gnt;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      pick;
    logic               pick_valid;
    logic               can_grant;
    logic [ADDR_W-1:0]  awaddr_q;
    logic [LEN_W-1:0]   awlen_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic [OUT_W-1:0]   outstanding;
    logic               bid_err_q;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               b_id_ok;
    logic [GW-1:0]      b_idx;

    // First requesting index at or after ptr, wrapping; MSB of the result flags a hit.
    // The scan runs from the farthest offset down so the nearest one wins.
    function automatic logic [GW:0] rr_search(input logic [N_REQ-1:0] reqs,
                                              input logic [GW-1:0]    ptr);
        logic [GW:0] res;
        int          j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (reqs[j]) begin
                res = {1'b1, GW'(j)};
            end
        end
        return res;
    endfunction

    assign {pick_valid, pick} = rr_search(req_awvalid, rr_ptr);
    assign can_grant = pick_valid && (outstanding < OUT_W'(MAX_OUTSTANDING));

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (can_grant)        state_nxt = ST_AW;
            ST_AW:   if (m_awready)        state_nxt = ST_W;
            ST_W:    if (w_hs && m_wlast)  state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_awvalid   = 1'b0;
        req_awready = '0;
        m_wvalid    = 1'b0;
        req_wready  = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wlast     = 1'b0;
        case (state)
            ST_AW: begin
                m_awvalid        = 1'b1;
                req_awready[gnt] = m_awready;
            end
            ST_W: begin
                m_wvalid        = req_wvalid[gnt];
                req_wready[gnt] = m_wready;
                m_wdata         = req_wdata[int'(gnt)*DATA_W +: DATA_W];
                m_wstrb         = '1;
                m_wlast         = (beat_cnt == awlen_q);
            end
            default: ;
        endcase
    end

    // Grant fields are captured once in IDLE and held, keeping AW stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == ST_IDLE && can_grant) begin
                gnt      <= pick;
                awaddr_q <= req_awaddr[int'(pick)*ADDR_W +: ADDR_W];
                awlen_q  <= req_awlen[int'(pick)*LEN_W +: LEN_W];
            end
            if (aw_hs) begin
                rr_ptr   <= (gnt == GW'(N_REQ - 1)) ? '0 : gnt + GW'(1);
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end

    assign m_awaddr = awaddr_q;
    assign m_awid   = ID_W'(gnt);
    assign m_awlen  = awlen_q;

    // Saturating at zero keeps a stray response (e.g. a bad ID) from wrapping the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
                default: ;
            endcase
        end
    end

    // Response routing is independent of the FSM; unknown IDs are swallowed.
    assign b_id_ok = (m_bid < ID_W'(N_REQ));
    assign b_idx   = m_bid[GW-1:0];

    always_comb begin
        req_bvalid = '0;
        m_bready   = 1'b1;
        if (b_id_ok) begin
            req_bvalid[b_idx] = m_bvalid;
            m_bready          = req_bready[b_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bid_err_q <= 1'b0;
        end else if (m_bvalid && !b_id_ok) begin
            bid_err_q <= 1'b1;
        end
    end

    assign bid_err = bid_err_q;

`ifdef AXI_HBM_WPARITY_EN
    assign m_wparity = wparity(m_wdata);
`else
    assign m_wparity = '0;
`endif

endmodule

// File: tb/tb_axi_hbm_wr_arb.sv
// Scoreboard bench for axi_hbm_wr_arb: directed bursts with a requester/B agent and a
// monitor that pops expected AW, W and routed-B entries on every observed handshake.

module tb_axi_hbm_wr_arb;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_awvalid, req_awready, req_wvalid, req_wready;
    logic [N-1:0]        req_bvalid, req_bready;
    logic [N*33-1:0]     req_awaddr;
    logic [N*4-1:0]      req_awlen;
    logic [N*256-1:0]    req_wdata;
    logic                m_awvalid, m_awready;
    logic [32:0]         m_awaddr;
    logic [5:0]          m_awid;
    logic [3:0]          m_awlen;
    logic                m_wvalid, m_wready, m_wlast;
    logic [255:0]        m_wdata;
    logic [31:0]         m_wstrb, m_wparity;
    logic                m_bvalid, m_bready;
    logic [5:0]          m_bid;
    logic                bid_err;

    axi_hbm_wr_arb #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req_awvalid(req_awvalid), .req_awready(req_awready),
        .req_awaddr(req_awaddr), .req_awlen(req_awlen),
        .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata),
        .req_bvalid(req_bvalid), .req_bready(req_bready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wparity(m_wparity),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
        .bid_err(bid_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  id;
        logic [32:0] addr;
        logic [3:0]  len;
    } aw_t;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } w_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    int         exp_b[$];
    logic [5:0] b_pend[$];
    int         exp_beat[N];
    int         wbeat[N];
    int         wpend[N];
    bit         auto_b;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Byte k of beat b from requester r; requester 0 beat 0 has byte 0 = 0x07.
    function automatic logic [255:0] make_data(input int r, input int b);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) begin
            d[8*k +: 8] = 8'(k*37 + r*5 + b*11 + 7);
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_par(input logic [255:0] d);
        logic [31:0] p;
        p = '0;
`ifdef AXI_HBM_WPARITY_EN
        for (int i = 0; i < 32; i++) begin
            p[i] = ^d[8*i +: 8];
        end
`endif
        return p;
    endfunction

    task automatic expect_burst(input int r, input logic [32:0] addr, input int len);
        exp_aw.push_back('{id: 6'(r), addr: addr, len: 4'(len)});
        for (int b = 0; b <= len; b++) begin
            exp_w.push_back('{data: make_data(r, exp_beat[r]), last: (b == len)});
            exp_beat[r]++;
        end
    endtask

    task automatic issue(input int r, input logic [32:0] addr, input int len);
        req_awaddr[r*33 +: 33] = addr;
        req_awlen[r*4 +: 4]    = 4'(len);
        req_awvalid[r]         = 1'b1;
    endtask

    task automatic push_b(input int id);
        b_pend.push_back(6'(id));
        if (id < N) exp_b.push_back(id);
    endtask

    function automatic bit is_idle();
        bit idle;
        idle = (exp_aw.size() == 0) && (exp_w.size() == 0) && (req_awvalid == '0);
        for (int r = 0; r < N; r++) begin
            if (wpend[r] != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    // Every wait helper returns at posedge+1, ready for the next stimulus step.
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!is_idle()) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while (exp_aw.size() != 0 || exp_w.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_b_idle(input string name, input int budget);
        int n = 0;
        while (b_pend.size() != 0 || m_bvalid || exp_b.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_aw_taken(input int r, input int budget);
        int n = 0;
        while (req_awvalid[r]) begin
            @(posedge clk); #1;
            n++;
            if (n > budget) begin
                fail_now("aw_taken_timeout");
                break;
            end
        end
    endtask

    // Requester and slave-side agent: sample handshakes on negedge, update after posedge.
    initial begin : agent
        forever begin
            logic [N-1:0]   aw_hs;
            logic [N-1:0]   w_hs;
            logic [N*4-1:0] lens;
            logic           b_hs;
            logic           m_aw_hs;
            logic [5:0]     aw_id;
            @(negedge clk);
            aw_hs   = req_awvalid & req_awready;
            w_hs    = req_wvalid & req_wready;
            lens    = req_awlen;
            b_hs    = m_bvalid && m_bready;
            m_aw_hs = m_awvalid && m_awready;
            aw_id   = m_awid;
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) begin
                if (aw_hs[r]) begin
                    req_awvalid[r] = 1'b0;
                    wpend[r] += int'(lens[r*4 +: 4]) + 1;
                end
                if (w_hs[r]) begin
                    wbeat[r]++;
                    wpend[r]--;
                end
                req_wvalid[r]            = (wpend[r] != 0);
                req_wdata[r*256 +: 256]  = make_data(r, wbeat[r]);
            end
            if (m_aw_hs && auto_b) push_b(int'(aw_id));
            if (b_hs) m_bvalid = 1'b0;
            if (!m_bvalid && b_pend.size() > 0) begin
                m_bid    = b_pend.pop_front();
                m_bvalid = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            aw_t e_aw;
            w_t  e_w;
            @(negedge clk);
            if (!rst) begin
                if (m_awvalid && m_awready) begin
                    if (exp_aw.size() == 0) begin
                        fail_now("aw_unexpected");
                    end else begin
                        e_aw = exp_aw.pop_front();
                        check("aw_id",   256'(m_awid),   256'(e_aw.id));
                        check("aw_addr", 256'(m_awaddr), 256'(e_aw.addr));
                        check("aw_len",  256'(m_awlen),  256'(e_aw.len));
                    end
                end
                if (m_wvalid && m_wready) begin
                    if (exp_w.size() == 0) begin
                        fail_now("w_unexpected");
                    end else begin
                        e_w = exp_w.pop_front();
                        check("w_data",   m_wdata,           e_w.data);
                        check("w_last",   256'(m_wlast),     256'(e_w.last));
                        check("w_strb",   256'(m_wstrb),     256'(32'hFFFF_FFFF));
                        check("w_parity", 256'(m_wparity),   256'(exp_par(e_w.data)));
                    end
                end
                for (int r = 0; r < N; r++) begin
                    if (req_bvalid[r] && req_bready[r]) begin
                        if (exp_b.size() == 0) fail_now("b_unexpected");
                        else check("b_route", 256'(r), 256'(exp_b.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst         = 1'b1;
        req_awvalid = '0;
        req_awaddr  = '0;
        req_awlen   = '0;
        req_wvalid  = '0;
        req_bready  = '0;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;
        m_bid       = '0;
        auto_b      = 1'b1;
        for (int r = 0; r < N; r++) begin
            exp_beat[r] = 0;
            wbeat[r]    = 0;
            wpend[r]    = 0;
            req_wdata[r*256 +: 256] = make_data(r, 0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_m_awvalid",   256'(m_awvalid),   256'(0));
        check("rst_m_wvalid",    256'(m_wvalid),    256'(0));
        check("rst_req_awready", 256'(req_awready), 256'(0));
        check("rst_req_wready",  256'(req_wready),  256'(0));
        check("rst_req_bvalid",  256'(req_bvalid),  256'(0));
        check("rst_m_bready",    256'(m_bready),    256'(0));
        check("rst_m_awaddr",    256'(m_awaddr),    256'(0));
        check("rst_m_awid",      256'(m_awid),      256'(0));
        check("rst_m_awlen",     256'(m_awlen),     256'(0));
        check("rst_bid_err",     256'(bid_err),     256'(0));

        @(posedge clk); #1;
        req_bready = '1;
        m_awready  = 1'b1;
        m_wready   = 1'b1;

        // Fairness: all four request, order 0,1,2,3 then 0 again.
        expect_burst(0, 33'h0_0000_1000, 0);
        expect_burst(1, 33'h0_0000_1100, 0);
        expect_burst(2, 33'h0_0000_1200, 0);
        expect_burst(3, 33'h0_0000_1300, 0);
        expect_burst(0, 33'h0_0000_2000, 0);
        issue(0, 33'h0_0000_1000, 0);
        issue(1, 33'h0_0000_1100, 0);
        issue(2, 33'h0_0000_1200, 0);
        issue(3, 33'h0_0000_1300, 0);
        wait_aw_taken(0, 50);
        issue(0, 33'h0_0000_2000, 0);
        wait_idle("fair_timeout", 200);

        // After a grant to 3 with 1 and 3 requesting, 1 wins next.
        expect_burst(3, 33'h0_0000_3000, 0);
        issue(3, 33'h0_0000_3000, 0);
        wait_aw_taken(3, 50);
        expect_burst(1, 33'h0_0000_3100, 0);
        expect_burst(3, 33'h0_0000_3200, 0);
        issue(1, 33'h0_0000_3100, 0);
        issue(3, 33'h0_0000_3200, 0);
        wait_idle("fair2_timeout", 200);

        // Single burst with one-cycle grant latency.
        expect_burst(2, 33'h1_0000_0040, 3);
        issue(2, 33'h1_0000_0040, 3);
        @(negedge clk);
        check("lat_idle_awvalid", 256'(m_awvalid), 256'(0));
        @(negedge clk);
        check("lat_awvalid", 256'(m_awvalid), 256'(1));
        wait_idle("single_timeout", 200);

        // AW backpressure: fields stable and no requester acceptance.
        m_awready = 1'b0;
        expect_burst(1, 33'h0_ABCD_E000, 2);
        issue(1, 33'h0_ABCD_E000, 2);
        for (int n = 0; n < 20 && !m_awvalid; n++) @(negedge clk);
        if (!m_awvalid) fail_now("bp_awvalid_timeout");
        for (int n = 0; n < 5; n++) begin
            check("bp_awvalid",    256'(m_awvalid),   256'(1));
            check("bp_awaddr",     256'(m_awaddr),    256'(33'h0_ABCD_E000));
            check("bp_awid",       256'(m_awid),      256'(1));
            check("bp_awlen",      256'(m_awlen),     256'(2));
            check("bp_req_awready",256'(req_awready), 256'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_awready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            m_wready = ~m_wready;
        end
        m_wready = 1'b1;
        wait_idle("bp_timeout", 200);
        wait_b_idle("bp_b_timeout", 100);

        // Outstanding limit of two with no responses returned.
        auto_b = 1'b0;
        expect_burst(2, 33'h0_0000_4200, 0);
        expect_burst(0, 33'h0_0000_4000, 0);
        issue(0, 33'h0_0000_4000, 0);
        issue(1, 33'h0_0000_4100, 0);
        issue(2, 33'h0_0000_4200, 0);
        wait_drained("lim_timeout", 100);
        m_awready = 1'b0;
        repeat (10) @(negedge clk);
        check("lim_req1_waiting", 256'(req_awvalid[1]), 256'(1));
        check("lim_no_awvalid",   256'(m_awvalid),      256'(0));

        // Free one slot, then make AW and B handshakes coincide.
        @(posedge clk); #1;
        req_bready[0] = 1'b0;
        expect_burst(1, 33'h0_0000_4100, 0);
        push_b(2);
        push_b(0);
        for (int n = 0; n < 40 && !(m_awvalid && m_bvalid && m_bid == 6'd0); n++) @(negedge clk);
        check("coinc_setup", 256'({m_awvalid, m_bvalid, m_bid}), 256'({1'b1, 1'b1, 6'd0}));
        @(posedge clk); #1;
        req_bready[0] = 1'b1;
        m_awready     = 1'b1;
        @(negedge clk);
        check("coinc_aw_hs", 256'(m_awvalid && m_awready), 256'(1));
        check("coinc_b_hs",  256'(m_bvalid && m_bready),   256'(1));
        wait_drained("coinc_timeout", 100);
        expect_burst(2, 33'h0_0000_4210, 0);
        issue(3, 33'h0_0000_4300, 0);
        issue(2, 33'h0_0000_4210, 0);
        wait_drained("coinc2_timeout", 100);
        repeat (10) @(negedge clk);
        check("coinc_req3_waiting", 256'(req_awvalid[3]), 256'(1));
        check("coinc_no_awvalid",   256'(m_awvalid),      256'(0));
        @(posedge clk); #1;
        expect_burst(3, 33'h0_0000_4300, 0);
        auto_b = 1'b1;
        push_b(1);
        push_b(2);
        wait_idle("release_timeout", 200);
        wait_b_idle("release_b_timeout", 100);

        // Unknown response ID is swallowed and flagged.
        push_b(7);
        for (int n = 0; n < 20 && !m_bvalid; n++) @(negedge clk);
        check("badid_bvalid",     256'(m_bvalid),   256'(1));
        check("badid_bready",     256'(m_bready),   256'(1));
        check("badid_req_bvalid", 256'(req_bvalid), 256'(0));
        @(negedge clk);
        check("bid_err_set", 256'(bid_err), 256'(1));
        repeat (5) @(negedge clk);
        check("bid_err_sticky", 256'(bid_err), 256'(1));
        @(posedge clk); #1;
        expect_burst(0, 33'h0_0000_5000, 1);
        issue(0, 33'h0_0000_5000, 1);
        wait_idle("post_badid_timeout", 200);
        wait_b_idle("post_badid_b_timeout", 100);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_bid_err",   256'(bid_err),   256'(0));
        check("rst2_m_awvalid", 256'(m_awvalid), 256'(0));

        check("end_exp_aw_empty", 256'(exp_aw.size()), 256'(0));
        check("end_exp_w_empty",  256'(exp_w.size()),  256'(0));
        check("end_exp_b_empty",  256'(exp_b.size()),  256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
